// File: rtl/ysyx_23060111_csr_pkg.sv
// Shared constants for the NPC register file / machine-mode CSR unit:
// CSR addresses, csr_op encodings, mstatus field positions and reset value,
// plus a small address decoder used by the top level.
package ysyx_23060111_csr_pkg;

   // Implemented machine-mode CSR addresses
   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

   // csr_op encodings
   typedef enum logic [1:0] {
      CSR_OP_NONE = 2'b00,
      CSR_OP_RW   = 2'b01,
      CSR_OP_RS   = 2'b10,
      CSR_OP_RC   = 2'b11
   } csr_op_t;

   // mstatus field positions
   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;

   // mstatus after reset: MPP = machine mode, interrupts disabled
   localparam logic [31:0] MSTATUS_RESET = 32'h0000_1800;

   // Width of one counter half as seen through the CSR space
   localparam int CNT_HALF = 32;

   // One-hot-free selector for the decoded CSR target
   typedef enum logic [3:0] {
      SEL_NONE,
      SEL_MSTATUS,
      SEL_MTVEC,
      SEL_MSCRATCH,
      SEL_MEPC,
      SEL_MCAUSE,
      SEL_MCYCLE,
      SEL_MCYCLEH,
      SEL_MINSTRET,
      SEL_MINSTRETH
   } csr_sel_t;

   // Map a raw 12-bit CSR address onto an implemented register (or none)
   function automatic csr_sel_t csr_decode(input logic [11:0] addr);
      csr_sel_t sel;
      case (addr)
         CSR_MSTATUS:   sel = SEL_MSTATUS;
         CSR_MTVEC:     sel = SEL_MTVEC;
         CSR_MSCRATCH:  sel = SEL_MSCRATCH;
         CSR_MEPC:      sel = SEL_MEPC;
         CSR_MCAUSE:    sel = SEL_MCAUSE;
         CSR_MCYCLE:    sel = SEL_MCYCLE;
         CSR_MCYCLEH:   sel = SEL_MCYCLEH;
         CSR_MINSTRET:  sel = SEL_MINSTRET;
         CSR_MINSTRETH: sel = SEL_MINSTRETH;
         default:       sel = SEL_NONE;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/ysyx_23060111_csr_counter.sv
// 64-bit free-running counter exposed as two 32-bit CSR halves.
// A write to either half replaces that half, holds the other, and
// suppresses the increment for that cycle. Wraps from 2^64-1 to 0.
module ysyx_23060111_csr_counter
   import ysyx_23060111_csr_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  inc,
   input  logic                  wr_lo,
   input  logic                  wr_hi,
   input  logic [CNT_HALF-1:0]   din,
   output logic [2*CNT_HALF-1:0] cnt
);

   logic [2*CNT_HALF-1:0] cnt_q;

   // Counter state: reset, half-replace on CSR write, otherwise count
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (wr_lo || wr_hi) begin
         if (wr_lo) cnt_q[CNT_HALF-1:0]          <= din;
         if (wr_hi) cnt_q[2*CNT_HALF-1:CNT_HALF] <= din;
      end else if (inc) begin
         // full-width add carries from the low half into the high half
         cnt_q <= cnt_q + 64'd1;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/ysyx_23060111_rf_csr.sv
// Unified GPR file and machine-mode CSR unit for the NPC core.
// - NR_READ combinational GPR read ports, one synchronous write port.
// - CSRRW/CSRRS/CSRRC on real 12-bit CSR addresses, ecall trap entry, mret.
// - Free-running 64-bit mcycle / minstret counters.
// Optional feature macro: YSYX_23060111_RF_BYPASS_EN enables same-cycle
// write-to-read forwarding on every GPR read port.
// DATA_WIDTH must be at least 32 (counter halves are 32 bits wide).
module ysyx_23060111_rf_csr
   import ysyx_23060111_csr_pkg::*;
#(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32,
   parameter int NR_READ    = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NR_READ*ADDR_WIDTH-1:0]   raddr,
   output logic [NR_READ*DATA_WIDTH-1:0]   rdata,
   input  logic                            wen,
   input  logic [ADDR_WIDTH-1:0]           waddr,
   input  logic [DATA_WIDTH-1:0]           wdata,
   input  logic [1:0]                      csr_op,
   input  logic [11:0]                     csr_addr,
   input  logic [DATA_WIDTH-1:0]           csr_src,
   output logic [DATA_WIDTH-1:0]           csr_rdata,
   output logic                            csr_illegal,
   input  logic                            trap_valid,
   input  logic [DATA_WIDTH-1:0]           trap_epc,
   input  logic [DATA_WIDTH-1:0]           trap_cause,
   input  logic                            mret_valid,
   input  logic                            retire,
   output logic [DATA_WIDTH-1:0]           mtvec_o,
   output logic [DATA_WIDTH-1:0]           mepc_o
);

   localparam int NREG = 1 << ADDR_WIDTH;

   // ------------------------------------------------------------------
   // General purpose registers
   // ------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] gpr [NREG];

   // GPR write port; x0 is never written so it stays zero
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) gpr[i] <= '0;
      end else if (wen && (waddr != '0)) begin
         gpr[waddr] <= wdata;
      end
   end

   for (genvar g = 0; g < NR_READ; g++) begin : g_rd
      logic [ADDR_WIDTH-1:0] idx;
      logic [DATA_WIDTH-1:0] val;

      assign idx = raddr[g*ADDR_WIDTH +: ADDR_WIDTH];

      // Read port mux: x0 reads zero, optional forwarding of the write port
      always_comb begin
         val = '0;
         if (idx != '0) val = gpr[idx];
`ifdef YSYX_23060111_RF_BYPASS_EN
         if (wen && (waddr == idx) && (idx != '0)) val = wdata;
`endif
      end

      assign rdata[g*DATA_WIDTH +: DATA_WIDTH] = val;
   end

   // ------------------------------------------------------------------
   // CSR decode and read-modify-write datapath
   // ------------------------------------------------------------------
   logic [DATA_WIDTH-1:0]   mstatus;
   logic [DATA_WIDTH-1:0]   mtvec;
   logic [DATA_WIDTH-1:0]   mscratch;
   logic [DATA_WIDTH-1:0]   mepc;
   logic [DATA_WIDTH-1:0]   mcause;
   logic [2*CNT_HALF-1:0]   mcycle;
   logic [2*CNT_HALF-1:0]   minstret;

   csr_op_t                 op;
   csr_sel_t                sel;
   logic                    csr_hit;
   logic                    csr_we;
   logic [DATA_WIDTH-1:0]   old_val;
   logic [DATA_WIDTH-1:0]   wval;

   assign op      = csr_op_t'(csr_op);
   assign sel     = csr_decode(csr_addr);
   assign csr_hit = (sel != SEL_NONE);
   assign csr_we  = (op != CSR_OP_NONE) && csr_hit;

   // Current value of the addressed CSR; unimplemented addresses read zero
   always_comb begin
      old_val = '0;
      case (sel)
         SEL_MSTATUS:   old_val = mstatus;
         SEL_MTVEC:     old_val = mtvec;
         SEL_MSCRATCH:  old_val = mscratch;
         SEL_MEPC:      old_val = mepc;
         SEL_MCAUSE:    old_val = mcause;
         SEL_MCYCLE:    old_val = DATA_WIDTH'(mcycle[CNT_HALF-1:0]);
         SEL_MCYCLEH:   old_val = DATA_WIDTH'(mcycle[2*CNT_HALF-1:CNT_HALF]);
         SEL_MINSTRET:  old_val = DATA_WIDTH'(minstret[CNT_HALF-1:0]);
         SEL_MINSTRETH: old_val = DATA_WIDTH'(minstret[2*CNT_HALF-1:CNT_HALF]);
         default:       old_val = '0;
      endcase
   end

   // New CSR value; RS/RC with a zero operand rewrite the old value unchanged
   always_comb begin
      wval = old_val;
      case (op)
         CSR_OP_RW: wval = csr_src;
         CSR_OP_RS: wval = old_val | csr_src;
         CSR_OP_RC: wval = old_val & ~csr_src;
         default:   wval = old_val;
      endcase
   end

   assign csr_rdata   = old_val;
   assign csr_illegal = (op != CSR_OP_NONE) && !csr_hit;

   // Per-register write strobes. Trap entry owns mstatus/mepc/mcause and
   // mret owns mstatus, so a colliding CSR instruction write is dropped.
   logic we_mstatus, we_mtvec, we_mscratch, we_mepc, we_mcause;
   logic we_mcycle_lo, we_mcycle_hi, we_minstret_lo, we_minstret_hi;

   assign we_mstatus     = csr_we && (sel == SEL_MSTATUS) && !trap_valid && !mret_valid;
   assign we_mtvec       = csr_we && (sel == SEL_MTVEC);
   assign we_mscratch    = csr_we && (sel == SEL_MSCRATCH);
   assign we_mepc        = csr_we && (sel == SEL_MEPC)   && !trap_valid;
   assign we_mcause      = csr_we && (sel == SEL_MCAUSE) && !trap_valid;
   assign we_mcycle_lo   = csr_we && (sel == SEL_MCYCLE);
   assign we_mcycle_hi   = csr_we && (sel == SEL_MCYCLEH);
   assign we_minstret_lo = csr_we && (sel == SEL_MINSTRET);
   assign we_minstret_hi = csr_we && (sel == SEL_MINSTRETH);

   // mstatus: trap entry > mret > CSR instruction write
   always_ff @(posedge clk) begin
      if (rst) begin
         mstatus <= DATA_WIDTH'(MSTATUS_RESET);
      end else if (trap_valid) begin
         mstatus[MSTATUS_MPIE]                  <= mstatus[MSTATUS_MIE];
         mstatus[MSTATUS_MIE]                   <= 1'b0;
         mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] <= 2'b11;
      end else if (mret_valid) begin
         mstatus[MSTATUS_MIE]                   <= mstatus[MSTATUS_MPIE];
         mstatus[MSTATUS_MPIE]                  <= 1'b1;
         mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] <= 2'b11;
      end else if (we_mstatus) begin
         mstatus <= wval;
      end
   end

   // mepc / mcause: trap entry captures PC and cause, else CSR write
   always_ff @(posedge clk) begin
      if (rst) begin
         mepc   <= '0;
         mcause <= '0;
      end else if (trap_valid) begin
         mepc   <= trap_epc;
         mcause <= trap_cause;
      end else begin
         if (we_mepc)   mepc   <= wval;
         if (we_mcause) mcause <= wval;
      end
   end

   // mtvec / mscratch: only written by CSR instructions
   always_ff @(posedge clk) begin
      if (rst) begin
         mtvec    <= '0;
         mscratch <= '0;
      end else begin
         if (we_mtvec)    mtvec    <= wval;
         if (we_mscratch) mscratch <= wval;
      end
   end

   // ------------------------------------------------------------------
   // Performance counters
   // ------------------------------------------------------------------
   ysyx_23060111_csr_counter u_mcycle (
      .clk   (clk),
      .rst   (rst),
      .inc   (1'b1),
      .wr_lo (we_mcycle_lo),
      .wr_hi (we_mcycle_hi),
      .din   (wval[CNT_HALF-1:0]),
      .cnt   (mcycle)
   );

   ysyx_23060111_csr_counter u_minstret (
      .clk   (clk),
      .rst   (rst),
      .inc   (retire),
      .wr_lo (we_minstret_lo),
      .wr_hi (we_minstret_hi),
      .din   (wval[CNT_HALF-1:0]),
      .cnt   (minstret)
   );

   assign mtvec_o = mtvec;
   assign mepc_o  = mepc;

endmodule

// File: tb/tb_ysyx_23060111_rf_csr.sv
// Self-checking bench for ysyx_23060111_rf_csr: a table of single-cycle
// vectors plus hand-written sequences for reset, counters and forwarding.
module tb_ysyx_23060111_rf_csr;

   localparam int AW = 4;
   localparam int DW = 32;
   localparam int NR = 2;

   logic              clk;
   logic              rst;
   logic [NR*AW-1:0]  raddr;
   logic [NR*DW-1:0]  rdata;
   logic              wen;
   logic [AW-1:0]     waddr;
   logic [DW-1:0]     wdata;
   logic [1:0]        csr_op;
   logic [11:0]       csr_addr;
   logic [DW-1:0]     csr_src;
   logic [DW-1:0]     csr_rdata;
   logic              csr_illegal;
   logic              trap_valid;
   logic [DW-1:0]     trap_epc;
   logic [DW-1:0]     trap_cause;
   logic              mret_valid;
   logic              retire;
   logic [DW-1:0]     mtvec_o;
   logic [DW-1:0]     mepc_o;

   ysyx_23060111_rf_csr #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .NR_READ    (NR)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .raddr       (raddr),
      .rdata       (rdata),
      .wen         (wen),
      .waddr       (waddr),
      .wdata       (wdata),
      .csr_op      (csr_op),
      .csr_addr    (csr_addr),
      .csr_src     (csr_src),
      .csr_rdata   (csr_rdata),
      .csr_illegal (csr_illegal),
      .trap_valid  (trap_valid),
      .trap_epc    (trap_epc),
      .trap_cause  (trap_cause),
      .mret_valid  (mret_valid),
      .retire      (retire),
      .mtvec_o     (mtvec_o),
      .mepc_o      (mepc_o)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // One cycle of stimulus plus expectations. e_csr/e_ill are sampled before
   // the clock edge; e_rd0/e_rd1/e_mtvec/e_mepc are sampled after it.
   typedef struct packed {
      logic        rst;
      logic        wen;
      logic [3:0]  waddr;
      logic [31:0] wdata;
      logic [1:0]  op;
      logic [11:0] addr;
      logic [31:0] src;
      logic        trap;
      logic [31:0] epc;
      logic [31:0] cause;
      logic        mret;
      logic        retire;
      logic [3:0]  ra0;
      logic [3:0]  ra1;
      logic [31:0] e_csr;
      logic        e_ill;
      logic [31:0] e_rd0;
      logic [31:0] e_rd1;
      logic [31:0] e_mtvec;
      logic [31:0] e_mepc;
   } vec_t;

   // ---------------- driver ----------------
   task automatic apply(input vec_t v, input string tag);
      @(negedge clk);
      rst        = v.rst;
      wen        = v.wen;
      waddr      = v.waddr;
      wdata      = v.wdata;
      csr_op     = v.op;
      csr_addr   = v.addr;
      csr_src    = v.src;
      trap_valid = v.trap;
      trap_epc   = v.epc;
      trap_cause = v.cause;
      mret_valid = v.mret;
      retire     = v.retire;
      raddr      = {v.ra1, v.ra0};
      exp_q.push_back(v.e_csr);
      exp_q.push_back({31'd0, v.e_ill});
      exp_q.push_back(v.e_rd0);
      exp_q.push_back(v.e_rd1);
      exp_q.push_back(v.e_mtvec);
      exp_q.push_back(v.e_mepc);
      #1;
      check({tag, " csr_rdata"},   csr_rdata,              exp_q.pop_front());
      check({tag, " csr_illegal"}, {31'd0, csr_illegal},   exp_q.pop_front());
      @(posedge clk);
      #1;
      check({tag, " rdata0"},      rdata[DW-1:0],          exp_q.pop_front());
      check({tag, " rdata1"},      rdata[2*DW-1:DW],       exp_q.pop_front());
      check({tag, " mtvec_o"},     mtvec_o,                exp_q.pop_front());
      check({tag, " mepc_o"},      mepc_o,                 exp_q.pop_front());
   endtask

   // Plain CSR access after the mid-run reset: GPRs, mtvec and mepc all zero
   function automatic vec_t hv(input logic [1:0] op, input logic [11:0] a,
                               input logic [31:0] src, input logic ret,
                               input logic [31:0] e);
      vec_t v;
      v        = '0;
      v.op     = op;
      v.addr   = a;
      v.src    = src;
      v.retire = ret;
      v.e_csr  = e;
      return v;
   endfunction

   vec_t tbl[24];

   initial begin
      // rst wen wa wdata op addr src trap epc cause mret ret ra0 ra1 | e_csr ill rd0 rd1 mtvec mepc
      tbl[0]  = '{1'b0,1'b0,4'd0,32'h0,        2'd0,12'h300,32'h0,        1'b0,32'h0,32'h0,1'b0,1'b0,4'd0,4'd5, 32'h1800,    1'b0,32'h0,32'h0,        32'h0,        32'h0};
      tbl[1]  = '{1'b0,1'b1,4'd5,32'hDEADBEEF, 2'd0,12'h000,32'h0,        1'b0,32'h0,32'h0,1'b0,1'b0,4'd0,4'd5, 32'h0,       1'b0,32'h0,32'hDEADBEEF, 32'h0,        32'h0};
      tbl[2]  = '{1'b0,1'b1,4'd0,32'h12345678, 2'd0,12'h000,32'h0,        1'b0,32'h0,32'h0,1'b0,1'b0,4'd0,4'd0, 32'h0,       1'b0,32'h0,32'h0,        32'h0,        32'h0};
      tbl[3]  = '{1'b0,1'b0,4'd0,32'h0,        2'd1,12'h305,32'h80000100, 1'b0,32'h0,32'h0,1'b0,1'b0,4'd5,4'd5, 32'h0,       1'b0,32'hDEADBEEF,32'hDEADBEEF,32'h80000100,32'h0};
      tbl[4]  = '{1'b0,1'b0,4'd0,32'h0,        2'd2,12'h305,32'h3,        1'b0,32'h0,32'h0,1'b0,1'b0,4'd5,4'd5, 32'h80000100,1'b0,32'hDEADBEEF,32'hDEADBEEF,32'h80000103,32'h0};
      tbl[5]  = '{1'b0,1'b0,4'd0,32'h0,        2'd3,12'h305,32'h1,        1'b0,32'h0,32'h0,1'b0,1'b0,4'd5,4'd5, 32'h80000103,1'b0,32'hDEADBEEF,32'hDEADBEEF,32'h80000102,32'h0};
      tbl[6]  = '{1'b0,1'b0,4'd0,32'h0,        2'd1,12'h300,32'h1808,     1'b0,32'h0,32'h0,1'b0,1'b0,4'd5,4'd5, 32'h1800,    1'b0,32'hDEADBEEF,32'hDEADBEEF,32'h80000102,32'h0};
      tbl[7]  = '{1'b0,1'b0,4'd0,32'h0,        2'd0,12'h300,32'h0,        1'b1,32'h80000040,32'd11,1'b0,1'b0,4'd5,4'd5, 32'h1808,1'b0,32'hDEADBEEF,32'hDEADBEEF,32'h80000102,32'h80000040};
      tbl[8]  = '{1'b0,1'b0,4'd0,32'h0,        2'd0,12'h342,32'h0,        1'b0,32'h0,32'h0,1'b0,1'b0,4'd5,4'd5, 32'd11,      1'b0,32'hDEADBEEF,32'hDEADBEEF,32'h80000102,32'h80000040};
      tbl[9]  = '{1'b0,1'b0,4'd0,32'h0,        2'd0,12'h300,32'h0,        1'b0,32'h0,32'h0,1'b0,1'b0,4'd5,4'd5, 32'h1880,    1'b0,32'hDEADBEEF,32'hDEADBEEF,32'h80000102,32'h80000040};
      tbl[10] = '{1'b0,1'b0,4'd0,32'h0,        2'd0,12'h300,32'h0,        1'b0,32'h0,32'h0,1'b1,1'b0,4'd5,4'd5, 32'h1880,    1'b0,32'hDEADBEEF,32'hDEADBEEF,32'h80000102,32'h80000040};
      tbl[11] = '{1'b0,1'b0,4'd0,32'h0,        2'd0,12'h300,32'h0,        1'b0,32'h0,32'h0,1'b0,1'b0,4'd5,4'd5, 32'h1888,    1'b0,32'hDEADBEEF,32'hDEADBEEF,32'h80000102,32'h80000040};
      tbl[12] = '{1'b0,1'b1,4'd6,32'hCAFEF00D, 2'd1,12'h341,32'h1234,     1'b1,32'h80000080,32'd2,1'b0,1'b0,4'd5,4'd6, 32'h80000040,1'b0,32'hDEADBEEF,32'hCAFEF00D,32'h80000102,32'h80000080};
      tbl[13] = '{1'b0,1'b0,4'd0,32'h0,        2'd0,12'h342,32'h0,        1'b0,32'h0,32'h0,1'b0,1'b0,4'd5,4'd5, 32'd2,       1'b0,32'hDEADBEEF,32'hDEADBEEF,32'h80000102,32'h80000080};
      tbl[14] = '{1'b0,1'b0,4'd0,32'h0,        2'd0,12'h300,32'h0,        1'b0,32'h0,32'h0,1'b0,1'b0,4'd5,4'd5, 32'h1880,    1'b0,32'hDEADBEEF,32'hDEADBEEF,32'h80000102,32'h80000080};
      tbl[15] = '{1'b0,1'b0,4'd0,32'h0,        2'd1,12'h7C0,32'hFFFFFFFF, 1'b0,32'h0,32'h0,1'b0,1'b0,4'd5,4'd5, 32'h0,       1'b1,32'hDEADBEEF,32'hDEADBEEF,32'h80000102,32'h80000080};
      tbl[16] = '{1'b0,1'b0,4'd0,32'h0,        2'd0,12'h7C0,32'h0,        1'b0,32'h0,32'h0,1'b0,1'b0,4'd5,4'd5, 32'h0,       1'b0,32'hDEADBEEF,32'hDEADBEEF,32'h80000102,32'h80000080};
      tbl[17] = '{1'b0,1'b0,4'd0,32'h0,        2'd1,12'h340,32'hA5A5A5A5, 1'b0,32'h0,32'h0,1'b0,1'b0,4'd5,4'd5, 32'h0,       1'b0,32'hDEADBEEF,32'hDEADBEEF,32'h80000102,32'h80000080};
      tbl[18] = '{1'b0,1'b0,4'd0,32'h0,        2'd2,12'h340,32'h0,        1'b0,32'h0,32'h0,1'b0,1'b0,4'd5,4'd5, 32'hA5A5A5A5,1'b0,32'hDEADBEEF,32'hDEADBEEF,32'h80000102,32'h80000080};
      tbl[19] = '{1'b0,1'b0,4'd0,32'h0,        2'd0,12'h340,32'h0,        1'b0,32'h0,32'h0,1'b0,1'b0,4'd5,4'd5, 32'hA5A5A5A5,1'b0,32'hDEADBEEF,32'hDEADBEEF,32'h80000102,32'h80000080};
      tbl[20] = '{1'b0,1'b0,4'd0,32'h0,        2'd1,12'h300,32'h0,        1'b0,32'h0,32'h0,1'b1,1'b0,4'd5,4'd5, 32'h1880,    1'b0,32'hDEADBEEF,32'hDEADBEEF,32'h80000102,32'h80000080};
      tbl[21] = '{1'b0,1'b0,4'd0,32'h0,        2'd0,12'h300,32'h0,        1'b0,32'h0,32'h0,1'b0,1'b0,4'd5,4'd5, 32'h1888,    1'b0,32'hDEADBEEF,32'hDEADBEEF,32'h80000102,32'h80000080};
      tbl[22] = '{1'b0,1'b0,4'd0,32'h0,        2'd1,12'h340,32'h11,       1'b0,32'h0,32'h0,1'b1,1'b0,4'd5,4'd5, 32'hA5A5A5A5,1'b0,32'hDEADBEEF,32'hDEADBEEF,32'h80000102,32'h80000080};
      tbl[23] = '{1'b0,1'b0,4'd0,32'h0,        2'd0,12'h340,32'h0,        1'b0,32'h0,32'h0,1'b0,1'b0,4'd5,4'd5, 32'h11,      1'b0,32'hDEADBEEF,32'hDEADBEEF,32'h80000102,32'h80000080};

      // initial reset, two cycles
      rst = 1'b1; wen = 1'b0; waddr = '0; wdata = '0;
      csr_op = 2'd0; csr_addr = '0; csr_src = '0;
      trap_valid = 1'b0; trap_epc = '0; trap_cause = '0;
      mret_valid = 1'b0; retire = 1'b0; raddr = '0;
      repeat (2) @(posedge clk);

      // table-driven vectors
      for (int i = 0; i < 24; i++) apply(tbl[i], $sformatf("tbl%0d", i));

      // reset in the middle of GPR write, CSR write and trap: all dropped
      apply('{1'b1,1'b1,4'd5,32'h11111111, 2'd1,12'h305,32'hFFFFFFFF, 1'b1,32'h44,32'd7,1'b0,1'b0,4'd5,4'd0,
              32'h80000102,1'b0,32'h0,32'h0,32'h0,32'h0}, "rst_mid");
      apply(hv(2'd0, 12'h300, 32'h0, 1'b0, 32'h1800), "rst_mstatus");

      // minstret counts retire cycles only
      apply(hv(2'd0, 12'hB02, 32'h0, 1'b1, 32'd0), "instret0");
      apply(hv(2'd0, 12'hB02, 32'h0, 1'b1, 32'd1), "instret1");
      apply(hv(2'd0, 12'hB02, 32'h0, 1'b1, 32'd2), "instret2");
      apply(hv(2'd0, 12'hB02, 32'h0, 1'b0, 32'd3), "instret3");
      apply(hv(2'd0, 12'hB82, 32'h0, 1'b0, 32'd0), "instreth");
      // write with retire=1 replaces value and suppresses the increment
      apply(hv(2'd1, 12'hB02, 32'h10, 1'b1, 32'd3), "instret_wr");
      apply(hv(2'd0, 12'hB02, 32'h0, 1'b0, 32'h10), "instret_hold");

      // mcycle: 8 edges since the reset edge, then carry and wrap
      apply(hv(2'd1, 12'hB00, 32'hFFFFFFFE, 1'b0, 32'd8), "mcycle_wr_lo");
      apply(hv(2'd1, 12'hB80, 32'h0,        1'b0, 32'd0), "mcycle_wr_hi");
      apply(hv(2'd0, 12'hB00, 32'h0,        1'b0, 32'hFFFFFFFE), "mcycle_noinc");
      apply(hv(2'd0, 12'hB00, 32'h0,        1'b0, 32'hFFFFFFFF), "mcycle_lo_max");
      apply(hv(2'd0, 12'hB00, 32'h0,        1'b0, 32'h0), "mcycle_carry_lo");
      apply(hv(2'd0, 12'hB80, 32'h0,        1'b0, 32'h1), "mcycle_carry_hi");
      apply(hv(2'd1, 12'hB80, 32'hFFFFFFFF, 1'b0, 32'h1), "mcycle_wr_hi2");
      apply(hv(2'd1, 12'hB00, 32'hFFFFFFFF, 1'b0, 32'h2), "mcycle_wr_lo2");
      apply(hv(2'd0, 12'hB80, 32'h0,        1'b0, 32'hFFFFFFFF), "mcycle_max");
      apply(hv(2'd0, 12'hB80, 32'h0,        1'b0, 32'h0), "mcycle_wrap_hi");
      apply(hv(2'd0, 12'hB00, 32'h0,        1'b0, 32'h1), "mcycle_wrap_lo");

      // same-cycle write/read of x7
      @(negedge clk);
      csr_op = 2'd0; csr_addr = 12'h000; retire = 1'b0;
      wen = 1'b1; waddr = 4'd7; wdata = 32'h77777777; raddr = {4'd7, 4'd0};
`ifdef YSYX_23060111_RF_BYPASS_EN
      exp_q.push_back(32'h77777777);
`else
      exp_q.push_back(32'h0);
`endif
      exp_q.push_back(32'h77777777);
      #1;
      check("bypass_same_cycle", rdata[2*DW-1:DW], exp_q.pop_front());
      @(posedge clk);
      #1;
      check("bypass_next_cycle", rdata[2*DW-1:DW], exp_q.pop_front());
      @(negedge clk);
      wen = 1'b0;

      // ---------------- report ----------------
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ysyx_23060111_rf_csr.md
Name: ysyx_23060111_rf_csr

Overview:
- Unified GPR file and machine-mode CSR unit for the NPC core, replacing the fixed 4-entry CSR array.
- Provides NR_READ combinational GPR read ports and one synchronous GPR write port.
- Decodes the real 12-bit CSR address and performs CSRRW/CSRRS/CSRRC read-modify-write, ecall trap entry and mret.
- Runs free-running mcycle/minstret counters; sits between decode (reads) and writeback (writes).

Parameters:
- ADDR_WIDTH, 4, GPR index width (4 = RV32E, 16 regs; 5 = RV32I).
- DATA_WIDTH, 32, GPR/CSR data width.
- NR_READ, 2, number of GPR read ports.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- raddr  in  NR_READ*ADDR_WIDTH  packed read indices; port i = bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- rdata  out  NR_READ*DATA_WIDTH  packed read data, same packing.
- wen  in  1  GPR write enable.
- waddr  in  ADDR_WIDTH  GPR write index.
- wdata  in  DATA_WIDTH  GPR write data.
- csr_op  in  2  00 none, 01 RW, 10 RS, 11 RC.
- csr_addr  in  12  CSR address.
- csr_src  in  DATA_WIDTH  rs1 value / write operand.
- csr_rdata  out  DATA_WIDTH  old CSR value (combinational).
- csr_illegal  out  1  csr_op!=0 and address not implemented.
- trap_valid  in  1  ecall/exception this cycle.
- trap_epc  in  DATA_WIDTH  PC to save.
- trap_cause  in  DATA_WIDTH  cause code.
- mret_valid  in  1  mret this cycle.
- retire  in  1  one instruction retired this cycle.
- mtvec_o  out  DATA_WIDTH  current mtvec (trap target).
- mepc_o  out  DATA_WIDTH  current mepc (mret target).

Behaviour:
- Reset: all GPRs 0; mstatus 0x0000_1800 (MPP=11); mtvec, mepc, mcause, mscratch 0; mcycle, minstret 0 (64-bit). Reads therefore return 0 after reset; csr_illegal 0 when csr_op=0.
- GPR reads: combinational; index 0 always returns 0. Write on the posedge when wen && waddr!=0. Without the bypass feature, a write is visible the cycle after.
- Implemented CSRs: mstatus 0x300, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mcycle 0xB00, mcycleh 0xB80, minstret 0xB02, minstreth 0xB82. Anything else sets csr_illegal and causes no state change; csr_rdata=0.
- CSR write value: RW = src; RS = old|src; RC = old&~src. RS/RC with src==0 still writes the same value (no side effects exist).
- Trap (trap_valid): mepc<=trap_epc, mcause<=trap_cause, mstatus.MPIE<=MIE, MIE<=0, MPP<=11.
- mret_valid: MIE<=MPIE, MPIE<=1, MPP<=11.
- Priority in one cycle: rst > trap > mret > CSR op. The lower-priority CSR op is dropped when it targets the same CSR field; GPR write is independent.
- mcycle increments every non-reset cycle. minstret increments when retire=1. Both are 64-bit with wrap at 2^64-1 -> 0.
- A CSR write to any half of a counter replaces that half, and the counter does not increment that cycle; the other half is held.
- Lower half at 0xFFFF_FFFF incrementing carries into the high half in the same cycle.
- rst mid-operation discards all pending writes that cycle.

Optional Feature:
- Macro: YSYX_23060111_RF_BYPASS_EN.
- Defined: each read port returns wdata when wen && waddr==raddr_i && waddr!=0 (same-cycle write-to-read forwarding).
- Not defined: reads return stored value; new data visible the next cycle.

Decomposition:
- Package ysyx_23060111_csr_pkg holds:
  - CSR address localparams;
  - csr_op encodings;
  - mstatus bit positions (MIE=3, MPIE=7, MPP=12:11);
  - the mstatus reset constant.
- Sub-module ysyx_23060111_csr_counter: 64-bit counter with inc, lo/hi write enables, data in, 64-bit out. Instantiated twice (mcycle, minstret).

Test Plan:
- Reset, then wen=1 waddr=5 wdata=0xDEADBEEF -> next cycle rdata port1 (raddr=5)=0xDEADBEEF. Write to x0 -> reads 0.
- csr_op=RW addr 0x305 src=0x8000_0100 -> csr_rdata=0 that cycle, mtvec_o=0x8000_0100 next. Then RS src=0x3 -> 0x8000_0103. Then RC src=0x1 -> 0x8000_0102.
- mstatus=0x1808 (MIE=1), trap_valid epc=0x8000_0040 cause=11 -> mepc=0x8000_0040, mcause=11, mstatus=0x1880. Then mret -> mstatus=0x1888.
- Same cycle: trap_valid and CSR RW to mepc src=0x1234 -> mepc=trap_epc. Concurrent GPR write still lands.
- RW mcycle=0xFFFF_FFFE, mcycleh=0 -> two cycles later mcycle=0, mcycleh=1. A write cycle does not increment. retire held 3 cycles -> minstret=3.
- csr_op=RW addr 0x7C0 -> csr_illegal=1, csr_rdata=0, no CSR changes. With the bypass macro: write x7 and read x7 in the same cycle -> new value.
